txstream: RTL and testbench

TXSTREAM -- requirements
Module: txstream

---
 rtl/txstream_pkg.sv | 26 ++
 rtl/txstream_if.sv | 29 ++
 rtl/txstream_iq_assembler.sv | 55 +++++
 rtl/txstream.sv | 189 ++++++++++++++++++
 tb/tb_txstream.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/txstream_pkg.sv
// -----------------------------------------------------------------------------
// txstream_pkg
// Shared definitions for the UDP IQ stream blocks (txstream, rxstream):
// parser state encoding, framing constants, default port and a saturating
// counter helper.
// -----------------------------------------------------------------------------
package txstream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEQ    = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DROP   = 2'd3
    } stream_state_e;

    localparam int          SEQ_BYTES           = 4;
    localparam int          BYTES_PER_SAMPLE    = 6;
    localparam logic [15:0] DEFAULT_TX_PORT     = 16'd1029;
    localparam int          DEFAULT_NUM_SAMPLES = 240;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/txstream_if.sv
// -----------------------------------------------------------------------------
// txstream_if
// Bundles the UDP payload input stream and the TX FIFO write port of txstream.
//   udp_rx_active : high on every cycle carrying a payload byte
//   udp_rx_data   : payload byte
//   to_port       : UDP destination port of the current packet
//   tx_data       : 48-bit IQ sample, [47:24] I, [23:0] Q
//   tx_wrreq      : one-cycle FIFO write strobe
//   tx_full       : FIFO full
// master = environment (UDP receiver + FIFO), slave = txstream.
// -----------------------------------------------------------------------------
interface txstream_if;
    logic        udp_rx_active;
    logic [7:0]  udp_rx_data;
    logic [15:0] to_port;
    logic [47:0] tx_data;
    logic        tx_wrreq;
    logic        tx_full;

    modport master (
        output udp_rx_active, udp_rx_data, to_port, tx_full,
        input  tx_data, tx_wrreq
    );

    modport slave (
        input  udp_rx_active, udp_rx_data, to_port, tx_full,
        output tx_data, tx_wrreq
    );
endinterface

// File: rtl/txstream_iq_assembler.sv
// -----------------------------------------------------------------------------
// txstream_iq_assembler (iq_assembler)
// Collects big-endian payload bytes into 48-bit IQ samples.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : discard any partial sample, byte counter back to 0
//   vld_i        : byte_i is a sample byte to accept this cycle
//   byte_i       : payload byte
//   sample_o     : assembled sample, valid while done_o is high
//   done_o       : high on the cycle the last byte of a sample is accepted
// -----------------------------------------------------------------------------
module txstream_iq_assembler
    import txstream_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        vld_i,
    input  logic [7:0]  byte_i,
    output logic [47:0] sample_o,
    output logic        done_o
);

    localparam int         SH_W      = (BYTES_PER_SAMPLE - 1) * 8;
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_SAMPLE - 1);

    logic [2:0]      cnt_q, cnt_d;
    logic [SH_W-1:0] sh_q, sh_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (vld_i) begin
            sh_d  = {sh_q[SH_W-9:0], byte_i};
            cnt_d = (cnt_q == LAST_BYTE) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    // The final byte is taken straight from the input so the sample is
    // available on the same cycle it completes.
    assign sample_o = {sh_q, byte_i};
    assign done_o   = vld_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/txstream.sv
// -----------------------------------------------------------------------------
// txstream
// Parses DUC IQ packets arriving over UDP and writes the samples into the TX
// FIFO. Packet payload: 4-byte big-endian sequence number followed by
// NUM_SAMPLES samples of 6 bytes (I[23:0], Q[23:0], big-endian).
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   run        : stream enable
//   have_ip    : Ethernet setup complete
//   bus        : UDP payload input and TX FIFO write port (txstream_if.slave)
//   seq_errors : saturating count of sequence-number discontinuities
//   overflow   : sticky, a sample was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module txstream
    import txstream_pkg::*;
#(
    parameter logic [15:0] TX_PORT     = DEFAULT_TX_PORT,
    parameter int          NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        have_ip,
    txstream_if.slave   bus,
    output logic [15:0] seq_errors,
    output logic        overflow
);

    localparam int SCW = $clog2(NUM_SAMPLES + 1);

    stream_state_e  state_q, state_d;
    logic [1:0]     seq_cnt_q, seq_cnt_d;
    logic [23:0]    seq_sh_q, seq_sh_d;
    logic [SCW-1:0] smp_cnt_q, smp_cnt_d;
    logic [31:0]    last_seq_q, last_seq_d;
    logic           seq_vld_q, seq_vld_d;
    logic [15:0]    seq_err_q, seq_err_d;
    logic           ovf_q, ovf_d;
    logic [47:0]    tx_data_q, tx_data_d;
    logic           tx_wrreq_q, tx_wrreq_d;

    logic           pkt_ok;
    logic           link_ok;
    logic [31:0]    seq_word;
    logic           asm_vld;
    logic           asm_clear;
    logic [47:0]    asm_sample;
    logic           asm_done;

    txstream_iq_assembler u_iq_assembler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (asm_clear),
        .vld_i    (asm_vld),
        .byte_i   (bus.udp_rx_data),
        .sample_o (asm_sample),
        .done_o   (asm_done)
    );

    // Outside SAMPLE the assembler is held cleared, so every entry into
    // SAMPLE starts on a sample boundary and aborted samples never leak.
    assign asm_clear = (state_q != ST_SAMPLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            seq_cnt_q  <= '0;
            seq_sh_q   <= '0;
            smp_cnt_q  <= '0;
            last_seq_q <= '0;
            seq_vld_q  <= 1'b0;
            seq_err_q  <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_wrreq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_cnt_q  <= seq_cnt_d;
            seq_sh_q   <= seq_sh_d;
            smp_cnt_q  <= smp_cnt_d;
            last_seq_q <= last_seq_d;
            seq_vld_q  <= seq_vld_d;
            seq_err_q  <= seq_err_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_wrreq_q <= tx_wrreq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = seq_cnt_q;
        seq_sh_d   = seq_sh_q;
        smp_cnt_d  = smp_cnt_q;
        last_seq_d = last_seq_q;
        seq_vld_d  = seq_vld_q;
        seq_err_d  = seq_err_q;
        ovf_d      = ovf_q;
        tx_data_d  = tx_data_q;
        tx_wrreq_d = 1'b0;
        asm_vld    = 1'b0;

        link_ok  = run && have_ip;
        pkt_ok   = link_ok && (bus.to_port == TX_PORT);
        seq_word = {seq_sh_q, bus.udp_rx_data};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.udp_rx_active) begin
                    if (pkt_ok) begin
                        // This byte is already sequence byte 0.
                        state_d   = ST_SEQ;
                        seq_sh_d  = {seq_sh_q[15:0], bus.udp_rx_data};
                        seq_cnt_d = 2'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_SEQ: begin
                if (!bus.udp_rx_active) begin
                    state_d = ST_IDLE;
                end else if (!link_ok) begin
                    state_d = ST_DROP;
                end else begin
                    seq_sh_d = {seq_sh_q[15:0], bus.udp_rx_data};
                    if (seq_cnt_q == 2'(SEQ_BYTES - 1)) begin
                        state_d   = ST_SAMPLE;
                        seq_cnt_d = 2'd0;
                        smp_cnt_d = '0;
                        if (seq_vld_q && (seq_word != last_seq_q + 32'd1)) begin
                            seq_err_d = sat_inc16(seq_err_q);
                        end
                        last_seq_d = seq_word;
                        seq_vld_d  = 1'b1;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 2'd1;
                    end
                end
            end

            ST_SAMPLE: begin
                if (!bus.udp_rx_active) begin
                    state_d = ST_IDLE;
                end else if (!link_ok) begin
                    state_d = ST_DROP;
                end else begin
                    asm_vld = 1'b1;
                    if (asm_done) begin
                        if (bus.tx_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            tx_data_d  = asm_sample;
                            tx_wrreq_d = 1'b1;
                        end
                        if (smp_cnt_q == SCW'(NUM_SAMPLES - 1)) begin
                            state_d   = ST_DROP;
                            smp_cnt_d = '0;
                        end else begin
                            smp_cnt_d = smp_cnt_q + SCW'(1);
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!bus.udp_rx_active) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Stopping the stream re-arms overflow and forgets the last sequence
        // number, so the first packet after restart is never an error.
        if (!run) begin
            ovf_d     = 1'b0;
            seq_vld_d = 1'b0;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wrreq = tx_wrreq_q;
    assign seq_errors   = seq_err_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_txstream.sv
// -----------------------------------------------------------------------------
// tb_txstream
// Drives UDP payload packets into txstream and compares FIFO writes, the
// sequence error counter and the overflow flag against a packet-level model.
// -----------------------------------------------------------------------------
module tb_txstream;

    localparam logic [15:0] TXP = 16'd1029;
    localparam int          NS  = 240;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        run     = 1'b0;
    logic        have_ip = 1'b0;
    logic [15:0] seq_errors;
    logic        overflow;

    txstream_if bus ();

    txstream #(
        .TX_PORT     (TXP),
        .NUM_SAMPLES (NS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .have_ip    (have_ip),
        .bus        (bus),
        .seq_errors (seq_errors),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    logic [7:0]  pkt [0:1599];
    logic [47:0] exp_q [$];
    int          exp_n  = 0;
    int          wr_cnt = 0;
    logic [31:0] m_last  = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_err   = '0;
    logic        m_ovf   = 1'b0;

    task automatic model_run_low();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_reset();
        m_last  = '0;
        m_valid = 1'b0;
        m_err   = '0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Bytes pkt[start..stop-1] form one packet as seen by the parser.
    task automatic model_pkt(input int start, input int stop, input logic acc, input int fidx);
        int          len;
        int          nsmp;
        logic [31:0] seq;
        logic [47:0] smp;
        len = stop - start;
        if (!acc || len < 4) return;
        seq = {pkt[start], pkt[start+1], pkt[start+2], pkt[start+3]};
        if (m_valid && seq != m_last + 32'd1 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_last  = seq;
        m_valid = 1'b1;
        nsmp = (len - 4) / 6;
        if (nsmp > NS) nsmp = NS;
        for (int k = 0; k < nsmp; k++) begin
            if (k == fidx) begin
                m_ovf = 1'b1;
            end else begin
                smp = '0;
                for (int b = 0; b < 6; b++) smp = {smp[39:0], pkt[start + 4 + 6*k + b]};
                exp_q.push_back(smp);
                exp_n++;
            end
        end
    endtask

    // Only the last byte of a sample decides; elsewhere full is noise.
    function automatic logic full_for(input int rel, input logic acc, input int fidx);
        if (acc && rel >= 4 && ((rel - 4) % 6) == 5 && ((rel - 4) / 6) < NS)
            return ((rel - 4) / 6) == fidx;
        return logic'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.tx_wrreq === 1'b1) begin
            wr_cnt++;
            check("wr_expected", 48'(exp_q.size() != 0), 48'd1);
            if (exp_q.size() != 0) check("wr_data", bus.tx_data, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill_pkt(input logic [31:0] seq, input bit ramp, input int len);
        pkt[0] = seq[31:24];
        pkt[1] = seq[23:16];
        pkt[2] = seq[15:8];
        pkt[3] = seq[7:0];
        for (int j = 4; j < len; j++) pkt[j] = ramp ? 8'(j - 3) : 8'($urandom);
    endtask

    task automatic gap(input int n, input logic r);
        bus.udp_rx_active = 1'b0;
        run = r;
        if (!r) model_run_low();
        for (int c = 0; c < n; c++) begin
            bus.udp_rx_data = 8'($urandom);
            bus.to_port     = 16'($urandom);
            bus.tx_full     = logic'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [15:0] port, input logic r, input logic ip, input int len,
                            input int fidx, input int rst_at, output int nwr);
        int   seg_end;
        int   seg_start;
        int   wr_before;
        int   fcur;
        logic acc;
        acc = r && ip && (port == TXP);
        run = r;
        have_ip = ip;
        if (!r) model_run_low();
        seg_end   = (rst_at >= 0 && rst_at < len) ? rst_at : len;
        seg_start = 0;
        fcur      = fidx;
        exp_n     = 0;
        wr_before = wr_cnt;
        model_pkt(0, seg_end, acc, fidx);
        for (int i = 0; i < len; i++) begin
            if (i == seg_end) begin
                check("pre_reset_drain", 48'(exp_q.size()), 48'd0);
                check("pre_reset_count", 48'(wr_cnt - wr_before), 48'(exp_n));
                reset_n = 1'b0;
                #1;
                check("rst_tx_data", bus.tx_data, 48'd0);
                check("rst_tx_wrreq", 48'(bus.tx_wrreq), 48'd0);
                check("rst_seq_errors", 48'(seq_errors), 48'd0);
                check("rst_overflow", 48'(overflow), 48'd0);
                model_reset();
                seg_start = i;
                fcur      = -1;
                exp_n     = 0;
                wr_before = wr_cnt;
                model_pkt(i, len, acc, -1);
                @(negedge clk);
                reset_n = 1'b1;
            end
            bus.udp_rx_active = 1'b1;
            bus.udp_rx_data   = pkt[i];
            bus.to_port       = port;
            bus.tx_full       = full_for(i - seg_start, acc, fcur);
            @(posedge clk);
            #1;
        end
        bus.udp_rx_active = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        nwr = wr_cnt - wr_before;
        check("wr_count", 48'(nwr), 48'(exp_n));
        check("seq_errors", 48'(seq_errors), 48'(m_err));
        check("overflow", 48'(overflow), 48'(m_ovf));
        check("exp_drained", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          nwr;
        logic [15:0] port;
        logic        r;
        logic        ip;
        int          len;
        int          fidx;
        logic [31:0] seq;

        bus.udp_rx_active = 1'b0;
        bus.udp_rx_data   = '0;
        bus.to_port       = '0;
        bus.tx_full       = 1'b0;
        reset_n           = 1'b0;
        for (int c = 0; c < 3; c++) @(posedge clk);
        #1;
        check("reset_tx_data", bus.tx_data, 48'd0);
        check("reset_tx_wrreq", 48'(bus.tx_wrreq), 48'd0);
        check("reset_seq_errors", 48'(seq_errors), 48'd0);
        check("reset_overflow", 48'(overflow), 48'd0);
        @(negedge clk);
        reset_n = 1'b1;
        gap(4, 1'b1);

        // Full packet, ramp samples, with trailing bytes beyond NUM_SAMPLES.
        fill_pkt(32'd0, 1'b1, 4 + 6*NS + 10);
        check("ramp_first_sample", {pkt[4], pkt[5], pkt[6], pkt[7], pkt[8], pkt[9]}, 48'h010203040506);
        send_pkt(TXP, 1'b1, 1'b1, 4 + 6*NS + 10, -1, -1, nwr);
        check("full_pkt_writes", 48'(nwr), 48'd240);
        check("full_pkt_seq_err", 48'(seq_errors), 48'd0);

        // Sequence 5, 7, 8 after a stream restart.
        gap(3, 1'b0);
        gap(2, 1'b1);
        fill_pkt(32'd5, 1'b0, 16);
        send_pkt(TXP, 1'b1, 1'b1, 16, -1, -1, nwr);
        gap(2, 1'b1);
        fill_pkt(32'd7, 1'b0, 16);
        send_pkt(TXP, 1'b1, 1'b1, 16, -1, -1, nwr);
        check("seq_gap_err", 48'(seq_errors), 48'd1);
        gap(2, 1'b1);
        fill_pkt(32'd8, 1'b0, 16);
        send_pkt(TXP, 1'b1, 1'b1, 16, -1, -1, nwr);
        check("seq_cont_err", 48'(seq_errors), 48'd1);

        // Wrong port, then no IP: nothing written; then a good packet.
        gap(2, 1'b1);
        fill_pkt(32'd9, 1'b0, 40);
        send_pkt(16'd1024, 1'b1, 1'b1, 40, -1, -1, nwr);
        check("bad_port_writes", 48'(nwr), 48'd0);
        gap(2, 1'b1);
        send_pkt(TXP, 1'b1, 1'b0, 40, -1, -1, nwr);
        check("no_ip_writes", 48'(nwr), 48'd0);
        gap(2, 1'b1);
        fill_pkt(32'd9, 1'b0, 16);
        send_pkt(TXP, 1'b1, 1'b1, 16, -1, -1, nwr);
        check("after_drop_writes", 48'(nwr), 48'd2);

        // FIFO full while the third sample completes.
        gap(2, 1'b1);
        fill_pkt(32'd10, 1'b0, 4 + 6*NS);
        send_pkt(TXP, 1'b1, 1'b1, 4 + 6*NS, 2, -1, nwr);
        check("full_writes", 48'(nwr), 48'd239);
        check("full_overflow", 48'(overflow), 48'd1);
        gap(3, 1'b0);
        check("overflow_cleared", 48'(overflow), 48'd0);

        // Truncated mid-sample, then the next packet parses normally.
        gap(2, 1'b1);
        fill_pkt(32'd11, 1'b0, 4 + 6*10 + 3);
        send_pkt(TXP, 1'b1, 1'b1, 4 + 6*10 + 3, -1, -1, nwr);
        check("trunc_writes", 48'(nwr), 48'd10);
        gap(2, 1'b1);
        fill_pkt(32'd12, 1'b0, 4 + 6*3);
        send_pkt(TXP, 1'b1, 1'b1, 4 + 6*3, -1, -1, nwr);
        check("after_trunc_writes", 48'(nwr), 48'd3);

        // Asynchronous reset mid-sample; remaining bytes start a new packet.
        gap(2, 1'b1);
        fill_pkt(32'd13, 1'b0, 4 + 6*8);
        send_pkt(TXP, 1'b1, 1'b1, 4 + 6*8, -1, 4 + 6*5 + 3, nwr);
        check("post_reset_writes", 48'(nwr), 48'd1);

        // Randomized packets.
        for (int p = 0; p < 30; p++) begin
            port = ($urandom_range(0, 9) < 8) ? TXP : 16'(1024 + $urandom_range(0, 3));
            r    = ($urandom_range(0, 9) < 8);
            ip   = ($urandom_range(0, 9) < 9);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : $urandom_range(4, 100);
            fidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            seq  = ($urandom_range(0, 2) != 0) ? m_last + 32'd1 : 32'($urandom);
            gap($urandom_range(1, 4), r);
            fill_pkt(seq, 1'b0, len);
            send_pkt(port, r, ip, len, fidx, -1, nwr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
